stall_controller: RTL and testbench

- Central pipeline sequencer for the 5-stage semiMIPS core.
- Combines load-use hazards, taken-branch flushes, multi-cycle mul/div occupancy and data-memory wait into:
  - PC enable,
  - per-stage pipeline-register enables and flushes,
  - a stall-cycle performance counter.
- Its PCEn output feeds the existing unstalling unit; its enables drive the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/stall_controller.sv | 149 ++++++++++++++
 tb/tb_stall_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stall_controller.sv
`default_nettype none
// ============================================================================
// stall_controller : semiMIPS pipeline sequencer (hazard stalls, flushes,
//                    mul/div occupancy, memory wait, stall-cycle counter)
// Rev 1.0
// ============================================================================
module stall_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6,
  parameter int STALL_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               LoadUse,
  input  logic               BranchTaken,
  input  logic               MulDivStart,
  input  logic               MemReq,
  input  logic               MemReady,
  output logic               PCEn,
  output logic               EnIFID,
  output logic               EnIDEX,
  output logic               EnEXMEM,
  output logic               EnMEMWB,
  output logic               FlushIFID,
  output logic               FlushIDEX,
  output logic               FlushEXMEM,
  output logic               MulDivBusy,
  output logic [STALL_W-1:0] StallCount
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] MULDIV = 2'd1;
  localparam logic [1:0] MDDONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic mem_wait;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic fl_ifid, fl_idex, fl_exmem, busy;

  assign mem_wait = MemReq & ~MemReady;

  // The start cycle is the first of MULDIV_CYCLES occupied cycles, so the
  // counter holds the cycles left including the current one; the last MULDIV
  // cycle (counter==1) decrements to 0, which is also the MDDONE hold value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_en    = 1'b0;
    en_ifid  = 1'b0;
    en_idex  = 1'b0;
    en_exmem = 1'b0;
    en_memwb = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    fl_exmem = 1'b0;
    busy     = 1'b0;
    case (state_q)
      RUN: begin
        if (!mem_wait) begin
          if (MulDivStart) begin
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            fl_exmem = 1'b1;
            busy     = 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = MULDIV;
          end else if (BranchTaken) begin
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
            fl_ifid = 1'b1;
            fl_idex = 1'b1;
          end else if (LoadUse) begin
            {en_idex, en_exmem, en_memwb} = 3'b111;
            fl_idex = 1'b1;
          end else begin
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
          end
        end
      end
      MULDIV: begin
        busy  = 1'b1;
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (cnt_q <= CNT_W'(1)) begin
          if (mem_wait) begin
            state_d = MDDONE;
          end else begin
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            state_d  = RUN;
          end
        end else if (!mem_wait) begin
          en_exmem = 1'b1;
          en_memwb = 1'b1;
          fl_exmem = 1'b1;
        end
      end
      MDDONE: begin
        busy  = 1'b1;
        cnt_d = '0;
        if (!mem_wait) begin
          en_exmem = 1'b1;
          en_memwb = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Everything is forced low while reset is held, independent of inputs.
  assign PCEn       = rst_n & pc_en;
  assign EnIFID     = rst_n & en_ifid;
  assign EnIDEX     = rst_n & en_idex;
  assign EnEXMEM    = rst_n & en_exmem;
  assign EnMEMWB    = rst_n & en_memwb;
  assign FlushIFID  = rst_n & fl_ifid;
  assign FlushIDEX  = rst_n & fl_idex;
  assign FlushEXMEM = rst_n & fl_exmem;
  assign MulDivBusy = rst_n & busy;
  assign StallCount = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_controller.sv
`default_nettype none
// ============================================================================
// tb_stall_controller : directed + random bench with cycle-level reference
// Rev 1.0
// ============================================================================
module tb_stall_controller;

  localparam int MD = 32;

  localparam logic [8:0] V_RUN   = 9'b11111_000_0;
  localparam logic [8:0] V_BR    = 9'b11111_110_0;
  localparam logic [8:0] V_LU    = 9'b00111_010_0;
  localparam logic [8:0] V_DRAIN = 9'b00011_001_1;
  localparam logic [8:0] V_REL   = 9'b00011_000_1;
  localparam logic [8:0] V_WAITB = 9'b00000_000_1;
  localparam logic [8:0] V_ZERO  = 9'b00000_000_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, lu, br, md, rq, rd;
  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_busy;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_busy;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  stall_controller #(.MULDIV_CYCLES(MD), .CNT_W(6), .STALL_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .LoadUse(lu), .BranchTaken(br), .MulDivStart(md),
    .MemReq(rq), .MemReady(rd), .PCEn(a_pc), .EnIFID(a_ifid), .EnIDEX(a_idex),
    .EnEXMEM(a_exmem), .EnMEMWB(a_memwb), .FlushIFID(a_fifid), .FlushIDEX(a_fidex),
    .FlushEXMEM(a_fexmem), .MulDivBusy(a_busy), .StallCount(a_stall)
  );

  stall_controller #(.MULDIV_CYCLES(MD), .CNT_W(6), .STALL_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .LoadUse(lu), .BranchTaken(br), .MulDivStart(md),
    .MemReq(rq), .MemReady(rd), .PCEn(b_pc), .EnIFID(b_ifid), .EnIDEX(b_idex),
    .EnEXMEM(b_exmem), .EnMEMWB(b_memwb), .FlushIFID(b_fifid), .FlushIDEX(b_fidex),
    .FlushEXMEM(b_fexmem), .MulDivBusy(b_busy), .StallCount(b_stall)
  );

  wire [8:0] a_vec = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_busy};
  wire [8:0] b_vec = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_busy};

  int errors = 0;
  int checks = 0;
  int busy_seen = 0;

  // Reference: occupied flag plus cycles remaining (0 = waiting to release).
  int m_busy = 0;
  int m_rem  = 0;
  int m_st16 = 0;
  int m_st4  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic i_lu, input logic i_br, input logic i_md,
                     input logic i_rq, input logic i_rd);
    logic [8:0] e;
    logic mw;
    @(negedge clk);
    lu = i_lu; br = i_br; md = i_md; rq = i_rq; rd = i_rd;
    #1;
    mw = i_rq & ~i_rd;
    if (m_busy == 0) begin
      if (mw)        e = V_ZERO;
      else if (i_md) begin e = V_DRAIN; m_busy = 1; m_rem = MD - 1; end
      else if (i_br) e = V_BR;
      else if (i_lu) e = V_LU;
      else           e = V_RUN;
    end else if (m_rem <= 1) begin
      if (mw) begin e = V_WAITB; m_rem = 0; end
      else    begin e = V_REL;   m_busy = 0; end
    end else begin
      e = mw ? V_WAITB : V_DRAIN;
      m_rem--;
    end
    chk("outs_a", {23'd0, a_vec}, {23'd0, e});
    chk("outs_b", {23'd0, b_vec}, {23'd0, e});
    if (a_busy === 1'b1) busy_seen++;
    if (!e[8]) begin
      if (m_st16 < 65535) m_st16++;
      if (m_st4 < 15)     m_st4++;
    end
    @(posedge clk);
    #1;
    chk("stall_a", {16'd0, a_stall}, m_st16);
    chk("stall_b", {28'd0, b_stall}, m_st4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    lu = 1'b1; br = 1'b1; md = 1'b1; rq = 1'b0; rd = 1'b1;
    #1;
    chk("rst_outs_a", {23'd0, a_vec}, 0);
    chk("rst_outs_b", {23'd0, b_vec}, 0);
    chk("rst_stall_a", {16'd0, a_stall}, 0);
    chk("rst_stall_b", {28'd0, b_stall}, 0);
    m_busy = 0; m_rem = 0; m_st16 = 0; m_st4 = 0;
    @(negedge clk);
    @(negedge clk);
    lu = 1'b0; br = 1'b0; md = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    rst_n = 1'b1;
    lu = 1'b0; br = 1'b0; md = 1'b0; rq = 1'b0; rd = 1'b0;
    do_reset();

    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1);

    // full mul/div occupancy without memory wait
    s0 = int'(a_stall);
    busy_seen = 0;
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, (i % 3) == 0, 0, 0, 0);
    chk("md_busy_cycles", busy_seen, MD);
    chk("md_stall_delta", int'(a_stall) - s0, MD);

    // memory wait straddling expiry, then three more held cycles
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 28; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 1, 0);
    chk("mddone_hold", {23'd0, a_vec}, {23'd0, V_WAITB});
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
    chk("sat4", {28'd0, b_stall}, 15);
    chk("sat16", {16'd0, a_stall}, 20);

    // reset in the middle of a mul/div
    do_reset();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 21; i++) cyc(0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      if ((i % 400) == 399) do_reset();
      cyc(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 12) == 0,
          ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
